// File: rtl/pe_operand_stage_pkg.sv
// rtl/pe_operand_stage_pkg.sv - shared mode encoding, register map and field positions
package pe_operand_stage_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_REG    = 2'd1,
      MODE_CONST  = 2'd2,
      MODE_DELAY  = 2'd3
   } mode_e;

   localparam logic [7:0] MODE_ADDR  = 8'h00;
   localparam logic [7:0] CONST_ADDR = 8'h01;

   localparam int ADDR_MSB  = 31;
   localparam int ADDR_LSB  = 24;
   localparam int MODE_MSB  = 1;
   localparam int MODE_LSB  = 0;
   localparam int DEPTH_MSB = 3;
   localparam int DEPTH_LSB = 2;

endpackage

// File: rtl/operand_delay_line.sv
// rtl/operand_delay_line.sv - free-running {valid, data} shift line with flush and depth tap
module operand_delay_line #(
   parameter int DATA_W    = 16,
   parameter int MAX_DELAY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   input  logic [1:0]        tap_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o
);

   logic [DATA_W-1:0] data_q  [MAX_DELAY];
   logic              valid_q [MAX_DELAY];

   always_ff @(posedge clk or posedge reset) begin
      if (reset || flush_i) begin
         for (int i = 0; i < MAX_DELAY; i++) begin
            data_q[i]  <= '0;
            valid_q[i] <= 1'b0;
         end
      end else begin
         data_q[0]  <= data_i;
         valid_q[0] <= valid_i;
         for (int i = 1; i < MAX_DELAY; i++) begin
            data_q[i]  <= data_q[i-1];
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   // Entry k carries a latency of k+1 cycles; a tap beyond the line reads as empty.
   always_comb begin
      data_o  = '0;
      valid_o = 1'b0;
      for (int i = 0; i < MAX_DELAY; i++) begin
         if (int'(tap_i) == i) begin
            data_o  = data_q[i];
            valid_o = valid_q[i];
         end
      end
   end

endmodule

// File: rtl/pe_operand_stage.sv
// rtl/pe_operand_stage.sv - PE operand stage: bypass, register, constant or delayed operand
module pe_operand_stage
   import pe_operand_stage_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int MAX_DELAY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_in_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_valid,
   input  logic              config_en,
   input  logic [31:0]       config_addr,
   input  logic [31:0]       config_data,
   output logic [31:0]       read_data
);

   mode_e             mode_q, mode_d;
   logic [1:0]        depth_q, depth_d;
   logic [DATA_W-1:0] const_q, const_d;
   logic [DATA_W-1:0] reg_data_q, reg_data_d;
   logic              reg_valid_q, reg_valid_d;

   logic              mode_wr;
   logic              const_wr;
   logic              flush;
   logic [DATA_W-1:0] dly_data;
   logic              dly_valid;
   logic              unused_cfg;

   assign unused_cfg = ^{config_addr[ADDR_LSB-1:0], config_data};

   assign mode_wr  = config_en && (config_addr[ADDR_MSB:ADDR_LSB] == MODE_ADDR);
   assign const_wr = config_en && (config_addr[ADDR_MSB:ADDR_LSB] == CONST_ADDR);
   // Only a real change of mode/depth flushes; rewriting the same value is harmless.
   assign flush    = mode_wr &&
                     (config_data[DEPTH_MSB:MODE_LSB] != {depth_q, mode_q});

   always_comb begin
      mode_d      = mode_q;
      depth_d     = depth_q;
      const_d     = const_q;
      reg_data_d  = reg_data_q;
      reg_valid_d = data_in_valid;
      if (mode_wr) begin
         mode_d  = mode_e'(config_data[MODE_MSB:MODE_LSB]);
         depth_d = config_data[DEPTH_MSB:DEPTH_LSB];
      end
      if (const_wr) begin
         const_d = config_data[DATA_W-1:0];
      end
      if (flush) begin
         reg_data_d  = '0;
         reg_valid_d = 1'b0;
      end else if (data_in_valid) begin
         reg_data_d = data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q      <= MODE_REG;
         depth_q     <= 2'd0;
         const_q     <= '0;
         reg_data_q  <= '0;
         reg_valid_q <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         depth_q     <= depth_d;
         const_q     <= const_d;
         reg_data_q  <= reg_data_d;
         reg_valid_q <= reg_valid_d;
      end
   end

   operand_delay_line #(
      .DATA_W    (DATA_W),
      .MAX_DELAY (MAX_DELAY)
   ) u_delay_line (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .data_i  (data_in),
      .valid_i (data_in_valid),
      .tap_i   (depth_q),
      .data_o  (dly_data),
      .valid_o (dly_valid)
   );

   always_comb begin
      data_out       = '0;
      data_out_valid = 1'b0;
      case (mode_q)
         MODE_BYPASS: begin
            data_out       = data_in;
            data_out_valid = data_in_valid;
         end
         MODE_REG: begin
            data_out       = reg_data_q;
            data_out_valid = reg_valid_q;
         end
         MODE_CONST: begin
            data_out       = const_q;
            data_out_valid = 1'b1;
         end
         MODE_DELAY: begin
            data_out       = dly_data;
            data_out_valid = dly_valid;
         end
         default: begin
            data_out       = '0;
            data_out_valid = 1'b0;
         end
      endcase
   end

   always_comb begin
      read_data = 32'h0;
      case (config_addr[ADDR_MSB:ADDR_LSB])
         MODE_ADDR:  read_data = {28'h0, depth_q, mode_q};
         CONST_ADDR: read_data = 32'(const_q);
         default:    read_data = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_pe_operand_stage.sv
// tb/tb_pe_operand_stage.sv - self-checking bench for pe_operand_stage against a history-queue model
module tb_pe_operand_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] data_in;
   logic        data_in_valid;
   logic [15:0] data_out;
   logic        data_out_valid;
   logic        config_en;
   logic [31:0] config_addr;
   logic [31:0] config_data;
   logic [31:0] read_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0]  m_mode;
   logic [1:0]  m_depth;
   logic [15:0] m_const;
   logic [15:0] m_hold;
   logic [16:0] samples[$];

   pe_operand_stage #(.DATA_W(16), .MAX_DELAY(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .config_en      (config_en),
      .config_addr    (config_addr),
      .config_data    (config_data),
      .read_data      (read_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = 2'd1;
      m_depth = 2'd0;
      m_const = 16'h0;
      m_hold  = 16'h0;
      samples.delete();
   endtask

   // Output is whatever entered `latency` edges ago, counted only since the last flush/reset.
   task automatic model_expect(input logic [15:0] din, input logic vin,
                               output logic [15:0] e_d, output logic e_v);
      int d;
      logic [16:0] s;
      e_d = 16'h0;
      e_v = 1'b0;
      case (m_mode)
         2'd0: begin e_d = din; e_v = vin; end
         2'd1: begin
            e_d = m_hold;
            e_v = (samples.size() > 0) ? samples[$][16] : 1'b0;
         end
         2'd2: begin e_d = m_const; e_v = 1'b1; end
         default: begin
            d = int'(m_depth) + 1;
            if (samples.size() >= d) begin
               s   = samples[samples.size() - d];
               e_v = s[16];
               e_d = s[15:0];
            end
         end
      endcase
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      case (addr[31:24])
         8'h00:   return {28'h0, m_depth, m_mode};
         8'h01:   return {16'h0, m_const};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge(input logic [15:0] din, input logic vin, input logic en,
                             input logic [31:0] addr, input logic [31:0] cd);
      logic fl;
      fl = en && addr[31:24] == 8'h00 && cd[3:0] != {m_depth, m_mode};
      if (en && addr[31:24] == 8'h00) begin
         m_mode  = cd[1:0];
         m_depth = cd[3:2];
      end
      if (en && addr[31:24] == 8'h01) m_const = cd[15:0];
      if (fl) begin
         samples.delete();
         m_hold = 16'h0;
      end else begin
         samples.push_back({vin, din});
         if (samples.size() > 8) void'(samples.pop_front());
         if (vin) m_hold = din;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [7:0] sel;
      case ($urandom_range(0, 2))
         0:       sel = 8'h00;
         1:       sel = 8'h01;
         default: sel = 8'h05;
      endcase
      return {sel, 24'($urandom)};
   endfunction

   // Called at a negedge: drive, check just after, then model the rising edge.
   task automatic cycle(input logic [15:0] din, input logic vin, input logic en,
                        input logic [31:0] addr, input logic [31:0] cd);
      logic [15:0] e_d;
      logic        e_v;
      data_in = din; data_in_valid = vin;
      config_en = en; config_addr = addr; config_data = cd;
      #1;
      model_expect(din, vin, e_d, e_v);
      chk("data_out", 32'(data_out), 32'(e_d));
      chk("data_out_valid", 32'(data_out_valid), 32'(e_v));
      chk("read_data", read_data, model_read(addr));
      @(posedge clk);
      model_edge(din, vin, en, addr, cd);
      @(negedge clk);
   endtask

   task automatic stream(input logic [15:0] d);
      cycle(d, 1'b1, 1'b0, rand_addr(), 32'($urandom));
   endtask

   task automatic wr(input logic [7:0] reg_sel, input logic [31:0] cd,
                     input logic [15:0] din, input logic vin);
      cycle(din, vin, 1'b1, {reg_sel, 24'($urandom)}, cd);
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++)
         cycle(16'($urandom), ($urandom_range(0, 3) != 0), 1'b0, rand_addr(), 32'($urandom));
   endtask

   initial begin
      data_in = 16'h0; data_in_valid = 1'b0;
      config_en = 1'b0; config_addr = 32'h0; config_data = 32'h0;
      model_reset();

      @(negedge clk);
      #1;
      chk("reset_dout", 32'(data_out), 32'h0);
      chk("reset_valid", 32'(data_out_valid), 32'h0);
      chk("reset_mode", read_data, 32'h1);
      config_addr = 32'h01AB_CDEF;
      #1;
      chk("reset_const", read_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 1; i <= 5; i++) stream(16'(i));
      cycle(16'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      rand_cycles(6);

      wr(8'h00, 32'h0000_000F, 16'h5555, 1'b1);
      for (int i = 0; i < 8; i++) stream(16'hA000 + 16'(i));
      wr(8'h00, 32'h0000_0007, 16'hA008, 1'b1);
      for (int i = 0; i < 6; i++) stream(16'hB000 + 16'(i));
      rand_cycles(12);

      wr(8'h00, 32'h0000_000B, 16'h1111, 1'b1);
      rand_cycles(6);
      wr(8'h00, 32'hFFFF_FFFB, 16'h2222, 1'b1);
      rand_cycles(6);
      wr(8'h05, 32'h0000_0003, 16'h3333, 1'b1);
      rand_cycles(4);

      wr(8'h01, 32'hFFFF_1234, 16'h4444, 1'b1);
      wr(8'h00, 32'h0000_0002, 16'h6666, 1'b1);
      for (int i = 0; i < 5; i++)
         cycle(16'($urandom), 1'(i), 1'b0, rand_addr(), 32'h0);
      wr(8'h01, 32'h0000_BEEF, 16'h7777, 1'b0);
      rand_cycles(4);

      wr(8'h00, 32'h0000_0000, 16'h8888, 1'b1);
      rand_cycles(4);
      cycle(16'hC0DE, 1'b1, 1'b0, 32'h00FF_FFFF, 32'h0);
      cycle(16'hC0DF, 1'b0, 1'b0, 32'h0112_3456, 32'h0);
      cycle(16'hC0E0, 1'b1, 1'b0, 32'h0500_0000, 32'h0);

      for (int i = 0; i < 160; i++) begin
         if ($urandom_range(0, 7) == 0)
            wr(8'($urandom_range(0, 2)), $urandom, 16'($urandom), 1'($urandom));
         else
            cycle(16'($urandom), ($urandom_range(0, 3) != 0), 1'b0, rand_addr(), 32'($urandom));
      end

      wr(8'h00, 32'h0000_000F, 16'h0, 1'b0);
      for (int i = 0; i < 6; i++) stream(16'hD000 + 16'(i));
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_dout", 32'(data_out), 32'h0);
      chk("async_rst_valid", 32'(data_out_valid), 32'h0);
      config_addr = 32'h0000_0000;
      #1;
      chk("async_rst_mode", read_data, 32'h1);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      cycle(16'h0, 1'b0, 1'b0, rand_addr(), 32'h0);
      for (int i = 0; i < 4; i++) stream(16'hE000 + 16'(i));
      rand_cycles(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_operand_stage.md
PE_OPERAND_STAGE -- requirements
Module: pe_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand width.
REQ-002 SHALL have parameter MAX_DELAY, default 4, meaning delay-line depth in entries.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port data_in, input, DATA_W, operand from the upstream connection box output.
REQ-006 SHALL have port data_in_valid, input, 1, data_in qualifier.
REQ-007 SHALL have port data_out, output, DATA_W, operand to the PE ALU.
REQ-008 SHALL have port data_out_valid, output, 1, data_out qualifier.
REQ-009 SHALL have port config_en, input, 1, config write strobe.
REQ-010 SHALL have port config_addr, input, 32, with bits [31:24] selecting the register and other bits ignored.
REQ-011 SHALL have port config_data, input, 32, config write data.
REQ-012 SHALL have port read_data, output, 32, combinational readback of the register selected by config_addr[31:24], or 0 for an unmapped address.

Function
REQ-013 SHALL implement config register 0 (MODE) with bits [1:0] mode (0 BYPASS, 1 REG, 2 CONST, 3 DELAY), bits [3:2] delay depth minus 1, and bits [31:4] read as 0.
REQ-014 SHALL implement config register 1 (CONST) with bits [DATA_W-1:0] holding the constant and upper bits read as 0.
REQ-015 SHALL write a register on a clk edge when config_en=1 and the address matches, and SHALL ignore writes to unmapped addresses.
REQ-016 In BYPASS mode, data_out and data_out_valid SHALL equal data_in and data_in_valid combinationally, with 0-cycle latency.
REQ-017 In REG mode, data_out and data_out_valid SHALL be data_in and data_in_valid registered once, with 1-cycle latency; the register SHALL load every cycle, and when valid=0 the data SHALL hold its old value.
REQ-018 In CONST mode, data_out SHALL equal CONST and data_out_valid SHALL be 1 permanently, with data_in ignored.
REQ-019 In DELAY mode, the block SHALL use a MAX_DELAY-entry shift line of {valid, data}, shifting every cycle, with the output tap at entry depth (1..4) giving a latency of depth cycles.
REQ-020 A MODE write that changes mode or depth SHALL flush the entire pipeline at that edge: all valid bits to 0 and data to 0.
REQ-021 data_in sampled on the same edge as a flushing MODE write SHALL be discarded.
REQ-022 A CONST write SHALL NOT flush, and a CONST-mode output SHALL reflect the new value the cycle after the write.
REQ-023 A MODE write with an identical value SHALL NOT flush.
REQ-024 In DELAY mode, a depth decrease SHALL produce data_out_valid=0 until new data has traversed the new depth.
REQ-025 The pipeline SHALL apply no backpressure and no stall, and SHALL accept data every cycle.

Reset
REQ-026 On reset, MODE SHALL be REG with depth field 0, CONST SHALL be 0, all pipeline entries SHALL be 0 and invalid, data_out SHALL be 0, and data_out_valid SHALL be 0.
REQ-027 Reset asserted mid-stream SHALL drop all in-flight data immediately (asynchronously).
REQ-028 The first valid output after reset deassertion SHALL appear 1 cycle after the first valid input.

Structure
REQ-029 A shared package SHALL hold the mode enum (BYPASS, REG, CONST, DELAY), the register-address constants (MODE_ADDR=0, CONST_ADDR=1), and the field bit positions.
REQ-030 The block SHALL contain one sub-module, operand_delay_line, holding the MAX_DELAY-entry shift line with a flush input and a depth-select tap.
REQ-031 The config registers and the output mux SHALL reside in pe_operand_stage.

Verification
REQ-032 Reset then stream 0x0001..0x0005, all valid -> in REG mode, data_out=0x0001 exactly 1 cycle after its input, and so on in order.
REQ-033 Write MODE=0x0F (DELAY, depth 4), then stream 0xA000..0xA007 -> data_out_valid=0 for 4 cycles, then outputs 0xA000 onward with 4-cycle latency.
REQ-034 Mid-stream in DELAY depth 4, write MODE=0x07 (depth 2) with data_in_valid=1 on the same cycle -> the same-cycle input is discarded, data_out_valid=0 for 2 cycles, then the new inputs appear with 2-cycle latency.
REQ-035 Write CONST=0x1234 config_data, then MODE=0x02 -> data_out=0x1234 and data_out_valid=1 from the next cycle while data_in toggles; a subsequent CONST=0xBEEF write shows 0xBEEF the next cycle with no valid gap.
REQ-036 Write MODE=0x00 -> data_out tracks data_in in the same cycle, and read_data at address 0x00xxxxxx returns 0x00000000, at address 0x01xxxxxx returns CONST, and at address 0x05xxxxxx returns 0.
REQ-037 Assert reset for 1 cycle mid-stream in DELAY mode -> data_out=0 and data_out_valid=0 immediately, and MODE reads back 0x00000001.
